// File: rtl/gpu_pkg.sv
// Shared core types: scheduler/fetcher state encodings and program-memory widths.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS = 8;
  localparam int PROGRAM_MEM_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_FETCH  = 3'b001,
    CORE_DECODE = 3'b010
  } core_state_t;

  typedef enum logic [2:0] {
    F_IDLE     = 3'b000,
    F_FETCHING = 3'b001,
    F_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/icache_lines.sv
// Direct-mapped instruction storage: one instruction per line, combinational lookup,
// registered fill and a bulk invalidate that takes priority over a same-cycle fill.
module icache_lines #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data,
  input  logic                 invalidate
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [DATA_BITS-1:0] data [LINES];

  logic [IDX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0] lookup_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;

  assign lookup_idx = lookup_addr[IDX_BITS-1:0];
  assign lookup_tag = lookup_addr[ADDR_BITS-1:IDX_BITS];
  assign fill_idx   = fill_addr[IDX_BITS-1:0];
  assign fill_tag   = fill_addr[ADDR_BITS-1:IDX_BITS];

  assign hit   = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
  assign rdata = data[lookup_idx];

  // Invalidate beats a same-cycle fill so a new kernel never sees a stale line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (invalidate) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetch stage: cache lookup on FETCH, program-memory read on a miss,
// and saturating hit/miss counters.
module icache_fetcher import gpu_pkg::*; #(
  parameter int PROGRAM_MEM_ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS,
  parameter int CACHE_LINES           = 8,
  parameter int COUNT_BITS            = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0]            hit_count,
  output logic [COUNT_BITS-1:0]            miss_count
);

  fetcher_state_t state, next_state;
  logic hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] rdata;
  logic fill_en;
  logic count_hit;
  logic count_miss;

  icache_lines #(
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS),
    .LINES    (CACHE_LINES)
  ) lines (
    .clk        (clk),
    .reset      (reset),
    .lookup_addr(current_pc),
    .hit        (hit),
    .rdata      (rdata),
    .fill_en    (fill_en),
    .fill_addr  (mem_read_address),
    .fill_data  (mem_read_data),
    .invalidate (invalidate)
  );

  assign fetcher_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= F_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fill_en    = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    case (state)
      F_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            next_state = F_FETCHED;
            count_hit  = 1'b1;
          end else begin
            next_state = F_FETCHING;
            count_miss = 1'b1;
          end
        end
      end
      F_FETCHING: begin
        if (mem_read_ready) begin
          next_state = F_FETCHED;
          fill_en    = 1'b1;
        end
      end
      F_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          next_state = F_IDLE;
        end
      end
      default: next_state = F_IDLE;
    endcase
  end

  // The request address stays latched through FETCHING and doubles as the fill address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      if (count_hit) begin
        instruction <= rdata;
      end
      if (count_miss) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= current_pc;
      end
      if (fill_en) begin
        instruction    <= mem_read_data;
        mem_read_valid <= 1'b0;
      end
      if (count_hit && hit_count != '1) begin
        hit_count <= hit_count + COUNT_BITS'(1);
      end
      if (count_miss && miss_count != '1) begin
        miss_count <= miss_count + COUNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher; a narrow-counter twin shares the stimulus to reach saturation.
module tb_icache_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        s_valid;
  logic [7:0]  s_address;
  logic [2:0]  s_state;
  logic [15:0] s_instruction;
  logic [3:0]  s_hits;
  logic [3:0]  s_misses;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_fetcher dut (
    .clk             (clk),
    .reset           (reset),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .invalidate      (invalidate),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  icache_fetcher #(.COUNT_BITS(4)) dut_small (
    .clk             (clk),
    .reset           (reset),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .invalidate      (invalidate),
    .mem_read_valid  (s_valid),
    .mem_read_address(s_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (s_state),
    .instruction     (s_instruction),
    .hit_count       (s_hits),
    .miss_count      (s_misses)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic decode();
    core_state = 3'b010;
    step();
    chk("decode_to_idle", fetcher_state, 3'b000);
    core_state = 3'b000;
  endtask

  // Miss path: memory answers in the delay-th FETCHING cycle, optionally with invalidate.
  task automatic fetch_miss(input logic [7:0] pc, input int delay, input logic [15:0] data,
                            input logic inv);
    core_state = 3'b001;
    current_pc = pc;
    step();
    for (int i = 0; i < delay; i++) begin
      chk("miss_fetching", fetcher_state, 3'b001);
      chk("miss_req_valid", mem_read_valid, 1'b1);
      chk("miss_req_addr", mem_read_address, pc);
      if (i == delay - 1) begin
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        invalidate     = inv;
      end
      step();
    end
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    invalidate     = 1'b0;
    chk("miss_fetched", fetcher_state, 3'b010);
    chk("miss_instr", instruction, data);
    chk("miss_req_drop", mem_read_valid, 1'b0);
  endtask

  task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] data);
    core_state = 3'b001;
    current_pc = pc;
    step();
    chk("hit_fetched", fetcher_state, 3'b010);
    chk("hit_instr", instruction, data);
    chk("hit_no_req", mem_read_valid, 1'b0);
  endtask

  initial begin
    reset          = 1'b0;
    core_state     = 3'b000;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    #12;
    chk("rst_state", fetcher_state, 3'b000);
    chk("rst_valid", mem_read_valid, 1'b0);
    chk("rst_addr", mem_read_address, 8'h00);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_hits", hit_count, 16'h0000);
    chk("rst_misses", miss_count, 16'h0000);
    reset = 1'b1;
    step();
    chk("idle_no_fetch", fetcher_state, 3'b000);

    // Cold miss, then ready must be ignored while FETCHED.
    fetch_miss(8'h00, 3, 16'hA5A5, 1'b0);
    chk("cold_misses", miss_count, 16'd1);
    chk("cold_hits", hit_count, 16'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1234;
    step();
    mem_read_ready = 1'b0;
    chk("fetched_hold_state", fetcher_state, 3'b010);
    chk("fetched_hold_instr", instruction, 16'hA5A5);
    decode();

    fetch_hit(8'h00, 16'hA5A5);
    chk("refetch_hits", hit_count, 16'd1);
    chk("refetch_misses", miss_count, 16'd1);
    decode();

    // Aliasing lines 3 and 11 evict each other.
    fetch_miss(8'h03, 1, 16'h1111, 1'b0);
    decode();
    fetch_miss(8'h0B, 2, 16'h2222, 1'b0);
    decode();
    fetch_miss(8'h03, 1, 16'h1111, 1'b0);
    decode();
    chk("alias_misses", miss_count, 16'd4);
    chk("alias_hits", hit_count, 16'd1);

    fetch_miss(8'hFF, 1, 16'hFFEE, 1'b0);
    decode();
    fetch_hit(8'hFF, 16'hFFEE);
    decode();
    chk("wrap_hits", hit_count, 16'd2);
    chk("wrap_misses", miss_count, 16'd5);

    // Invalidate coinciding with the fill: data delivered, line left invalid.
    fetch_miss(8'h20, 2, 16'h3333, 1'b1);
    decode();
    fetch_miss(8'h20, 1, 16'h3333, 1'b0);
    decode();
    fetch_miss(8'hFF, 1, 16'hFFEE, 1'b0);
    decode();
    chk("inv_fill_misses", miss_count, 16'd8);

    // Invalidate coinciding with a lookup: the lookup still hits.
    core_state = 3'b001;
    current_pc = 8'h20;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    chk("inv_hit_state", fetcher_state, 3'b010);
    chk("inv_hit_instr", instruction, 16'h3333);
    chk("inv_hit_hits", hit_count, 16'd3);
    decode();
    fetch_miss(8'h20, 1, 16'h3333, 1'b0);
    decode();
    chk("inv_hit_misses", miss_count, 16'd9);

    // Asynchronous reset in the middle of a request.
    core_state = 3'b001;
    current_pc = 8'h05;
    step();
    chk("pre_rst_valid", mem_read_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", mem_read_valid, 1'b0);
    chk("async_rst_state", fetcher_state, 3'b000);
    chk("async_rst_misses", miss_count, 16'd0);
    core_state = 3'b000;
    reset = 1'b1;
    step();
    fetch_miss(8'h20, 1, 16'h3333, 1'b0);
    decode();
    chk("post_rst_misses", miss_count, 16'd1);
    chk("post_rst_hits", hit_count, 16'd0);

    // Twenty hits: the 4-bit twin saturates, the 16-bit counter keeps going.
    for (int i = 0; i < 20; i++) begin
      fetch_hit(8'h20, 16'h3333);
      decode();
    end
    chk("sat_main_hits", hit_count, 16'd20);
    chk("sat_main_misses", miss_count, 16'd1);
    chk("sat_small_hits", s_hits, 4'hF);
    chk("sat_small_misses", s_misses, 4'd1);
    chk("sat_small_state", s_state, 3'b000);
    chk("sat_small_instr", s_instruction, 16'h3333);
    chk("sat_small_valid", s_valid, 1'b0);
    chk("sat_small_addr", s_address, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
